// File: rtl/dm_lsu_pkg.sv
// Shared types and constants for the dm_lsu load/store unit.
// DM_LSU_MISALIGN_CHECK_EN adds the ERR state used for misaligned requests.
package lsu_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } lsu_size_e;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        LD_DONE,
        MERGE,
        WR,
        ST_DONE
`ifdef DM_LSU_MISALIGN_CHECK_EN
        ,
        ERR
`endif
    } lsu_state_e;

    localparam logic [31:0] DM_WR_ALL = 32'hFFFF_FFFF;

    function automatic lsu_size_e decode_size(input logic [1:0] raw);
        case (raw)
            2'b00:   decode_size = BYTE;
            2'b01:   decode_size = HALF;
            default: decode_size = WORD;
        endcase
    endfunction

    function automatic logic is_misaligned(input lsu_size_e size, input logic [1:0] off);
        case (size)
            HALF:    is_misaligned = off[0];
            WORD:    is_misaligned = (off != 2'b00);
            default: is_misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dm_lsu_if.sv
// Request/response handshake between the MEM stage (master) and dm_lsu (slave).
interface dm_lsu_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/dm_lsu_align.sv
// Combinational little-endian lane handling: load select/extend and store lane merge.
module dm_lsu_align
    import lsu_pkg::*;
(
    input  lsu_size_e   i_size,
    input  logic [1:0]  i_off,
    input  logic        i_unsigned,
    input  logic [31:0] i_rword,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_ldata,
    output logic [31:0] o_merged
);

    logic [4:0]  w_bitpos;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_bitpos = {i_off, 3'b000};
    assign w_byte   = i_rword[w_bitpos +: 8];
    assign w_half   = i_off[1] ? i_rword[31:16] : i_rword[15:0];

    always_comb begin
        o_ldata  = i_rword;
        o_merged = i_wdata;
        case (i_size)
            BYTE: begin
                o_ldata  = {{24{~i_unsigned & w_byte[7]}}, w_byte};
                o_merged = i_rword;
                o_merged[w_bitpos +: 8] = i_wdata[7:0];
            end
            HALF: begin
                o_ldata  = {{16{~i_unsigned & w_half[15]}}, w_half};
                o_merged = i_rword;
                if (i_off[1]) o_merged[31:16] = i_wdata[15:0];
                else          o_merged[15:0]  = i_wdata[15:0];
            end
            default: begin
                o_ldata  = i_rword;
                o_merged = i_wdata;
            end
        endcase
    end

endmodule

// File: rtl/dm_lsu.sv
// MEM-stage load/store unit: word accesses on DM_*, read-modify-write for sub-word stores.
// DM_LSU_MISALIGN_CHECK_EN: misaligned requests answer with resp_err; otherwise they are aligned down.
module dm_lsu
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    dm_lsu_if.slave     bus,
    output logic        DM_enable,
    output logic [31:0] DM_write,
    output logic [31:0] DM_address,
    output logic [31:0] DM_in,
    input  logic [31:0] DM_out
);

    lsu_state_e  r_state;
    lsu_state_e  w_next;
    logic [31:0] r_addr;
    lsu_size_e   r_size;
    logic        r_we;
    logic        r_unsigned;
    logic [31:0] r_wdata;
    logic [31:0] r_merge;

    lsu_size_e   w_req_size;
    logic        w_accept;
    logic [31:0] w_acc_addr;
    logic [31:0] w_ldata;
    logic [31:0] w_merged;

    assign w_req_size = decode_size(bus.req_size);
    assign w_accept   = bus.req_valid && (r_state == IDLE);

`ifdef DM_LSU_MISALIGN_CHECK_EN
    logic w_misal;
    assign w_misal    = is_misaligned(w_req_size, bus.req_addr[1:0]);
    assign w_acc_addr = bus.req_addr;
`else
    always_comb begin
        w_acc_addr = bus.req_addr;
        case (w_req_size)
            HALF:    w_acc_addr[0]   = 1'b0;
            WORD:    w_acc_addr[1:0] = 2'b00;
            default: ;
        endcase
    end
`endif

    dm_lsu_align u_align (
        .i_size     (r_size),
        .i_off      (r_addr[1:0]),
        .i_unsigned (r_unsigned),
        .i_rword    (DM_out),
        .i_wdata    (r_wdata),
        .o_ldata    (w_ldata),
        .o_merged   (w_merged)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
`ifdef DM_LSU_MISALIGN_CHECK_EN
                    if (w_misal)                  w_next = ERR;
                    else
`endif
                    if (!bus.req_we)              w_next = RD;
                    else if (w_req_size == WORD)  w_next = WR;
                    else                          w_next = RD;
                end
            end
            RD:      w_next = r_we ? MERGE : LD_DONE;
            LD_DONE: w_next = IDLE;
            MERGE:   w_next = WR;
            WR:      w_next = ST_DONE;
            ST_DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr     <= '0;
            r_size     <= BYTE;
            r_we       <= 1'b0;
            r_unsigned <= 1'b0;
            r_wdata    <= '0;
            r_merge    <= '0;
        end else begin
            if (w_accept) begin
                r_addr     <= w_acc_addr;
                r_size     <= w_req_size;
                r_we       <= bus.req_we;
                r_unsigned <= bus.req_unsigned;
                r_wdata    <= bus.req_wdata;
            end
            // Old word arrives in MERGE; fold in the store lanes so WR drives it as-is.
            if (r_state == MERGE) r_merge <= w_merged;
        end
    end

    always_comb begin
        bus.req_ready  = (r_state == IDLE);
        bus.resp_valid = 1'b0;
        bus.resp_rdata = '0;
        bus.resp_err   = 1'b0;
        DM_enable      = 1'b0;
        DM_write       = '0;
        DM_address     = '0;
        DM_in          = '0;
        case (r_state)
            RD: begin
                DM_enable  = 1'b1;
                DM_address = {2'b00, r_addr[31:2]};
            end
            LD_DONE: begin
                bus.resp_valid = 1'b1;
                bus.resp_rdata = w_ldata;
            end
            WR: begin
                DM_enable  = 1'b1;
                DM_write   = DM_WR_ALL;
                DM_address = {2'b00, r_addr[31:2]};
                DM_in      = (r_size == WORD) ? r_wdata : r_merge;
            end
            ST_DONE: bus.resp_valid = 1'b1;
`ifdef DM_LSU_MISALIGN_CHECK_EN
            ERR: begin
                bus.resp_valid = 1'b1;
                bus.resp_err   = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dm_lsu.sv
// Directed bench for dm_lsu with a behavioural 65536-word data memory.
module tb_dm_lsu;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        DM_enable;
    logic [31:0] DM_write;
    logic [31:0] DM_address;
    logic [31:0] DM_in;
    logic [31:0] DM_out = '0;

    logic [31:0] mem [0:65535];
    int unsigned wr_count = 0;
    int unsigned n_tests = 0;
    int unsigned n_fail = 0;

    logic [31:0] ob_en [1:6];
    logic [31:0] ob_wr [1:6];
    logic [31:0] ob_ad [1:6];
    logic [31:0] ob_in [1:6];
    logic [31:0] ob_rd [1:6];
    logic [31:0] ob_er [1:6];
    logic [31:0] lat;
    logic [31:0] en_cnt;
    int unsigned wc0;

    always #5 clk = ~clk;

    dm_lsu_if bus ();

    dm_lsu dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .DM_enable  (DM_enable),
        .DM_write   (DM_write),
        .DM_address (DM_address),
        .DM_in      (DM_in),
        .DM_out     (DM_out)
    );

    always @(posedge clk) begin
        if (DM_enable && DM_write == 32'hFFFF_FFFF) begin
            mem[DM_address[15:0]] <= DM_in;
            wr_count <= wr_count + 1;
        end
        DM_out <= (DM_enable && DM_write == 32'h0) ? mem[DM_address[15:0]] : 32'h0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd);
        @(negedge clk);
        chk("ready_before_req", {31'b0, bus.req_ready}, 32'd1);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wd;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    // Samples cycles A+1..A+n at the falling edge; lat is the first resp_valid cycle.
    task automatic observe(input int n);
        lat    = 0;
        en_cnt = 0;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            ob_en[c] = {31'b0, DM_enable};
            ob_wr[c] = DM_write;
            ob_ad[c] = DM_address;
            ob_in[c] = DM_in;
            ob_rd[c] = bus.resp_rdata;
            ob_er[c] = {31'b0, bus.resp_err};
            if (DM_enable) en_cnt = en_cnt + 1;
            if (bus.resp_valid && lat == 0) lat = c;
        end
    endtask

    task automatic load(input string tag, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] exp);
        issue(1'b0, sz, uns, addr, 32'h0);
        observe(2);
        chk({tag, "_lat"}, lat, 32'd2);
        chk({tag, "_data"}, ob_rd[2], exp);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = '0;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;

        #12;
        chk("rst_ready",   {31'b0, bus.req_ready},  32'd1);
        chk("rst_rvalid",  {31'b0, bus.resp_valid}, 32'd0);
        chk("rst_rdata",   bus.resp_rdata,          32'd0);
        chk("rst_err",     {31'b0, bus.resp_err},   32'd0);
        chk("rst_enable",  {31'b0, DM_enable},      32'd0);
        chk("rst_write",   DM_write,                32'd0);
        chk("rst_address", DM_address,              32'd0);
        chk("rst_in",      DM_in,                   32'd0);
        @(negedge clk);
        rst = 1'b1;

        issue(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEAD_BEEF);
        observe(2);
        chk("wst_en",   ob_en[1], 32'd1);
        chk("wst_wr",   ob_wr[1], 32'hFFFF_FFFF);
        chk("wst_addr", ob_ad[1], 32'h40);
        chk("wst_in",   ob_in[1], 32'hDEAD_BEEF);
        chk("wst_lat",  lat,      32'd2);
        chk("wst_rd",   ob_rd[2], 32'h0);

        issue(1'b0, 2'b00, 1'b0, 32'h103, 32'h0);
        observe(2);
        chk("lb_en",   ob_en[1], 32'd1);
        chk("lb_wr",   ob_wr[1], 32'h0);
        chk("lb_addr", ob_ad[1], 32'h40);
        chk("lb_lat",  lat,      32'd2);
        chk("lb_data", ob_rd[2], 32'hFFFF_FFDE);

        load("lhu_102", 2'b01, 1'b1, 32'h102, 32'h0000_DEAD);

`ifdef DM_LSU_MISALIGN_CHECK_EN
        issue(1'b0, 2'b01, 1'b0, 32'h101, 32'h0);
        observe(1);
        chk("mis_lat", lat,      32'd1);
        chk("mis_err", ob_er[1], 32'd1);
        chk("mis_en",  en_cnt,   32'd0);
        chk("mis_rd",  ob_rd[1], 32'd0);
`else
        load("lh_101_aligned", 2'b01, 1'b0, 32'h101, 32'hFFFF_BEEF);
`endif

        issue(1'b1, 2'b00, 1'b0, 32'h101, 32'h0000_005A);
        observe(4);
        chk("sb_rd_en",  ob_en[1], 32'd1);
        chk("sb_rd_wr",  ob_wr[1], 32'h0);
        chk("sb_mrg_en", ob_en[2], 32'd0);
        chk("sb_wr_en",  ob_en[3], 32'd1);
        chk("sb_wr_wr",  ob_wr[3], 32'hFFFF_FFFF);
        chk("sb_wr_in",  ob_in[3], 32'hDEAD_5AEF);
        chk("sb_lat",    lat,      32'd4);

        load("lw_100", 2'b10, 1'b0, 32'h100, 32'hDEAD_5AEF);

        issue(1'b1, 2'b01, 1'b0, 32'h102, 32'h1234_CAFE);
        observe(4);
        chk("sh_wr_in", ob_in[3], 32'hCAFE_5AEF);
        chk("sh_lat",   lat,      32'd4);

        load("lbu_103",   2'b00, 1'b1, 32'h103, 32'h0000_00CA);
        load("lb_101",    2'b00, 1'b0, 32'h101, 32'h0000_005A);
        load("lh_100",    2'b01, 1'b0, 32'h100, 32'h0000_5AEF);
        load("lh_102",    2'b01, 1'b0, 32'h102, 32'hFFFF_CAFE);
        load("lw_size11", 2'b11, 1'b0, 32'h100, 32'hCAFE_5AEF);

`ifdef DM_LSU_MISALIGN_CHECK_EN
        issue(1'b1, 2'b10, 1'b0, 32'h206, 32'h1234_5678);
        observe(1);
        chk("mws_err", ob_er[1], 32'd1);
        chk("mws_en",  en_cnt,   32'd0);
        load("lw_204", 2'b10, 1'b0, 32'h204, 32'h0);
`else
        issue(1'b1, 2'b10, 1'b0, 32'h206, 32'h1234_5678);
        observe(2);
        chk("mws_addr", ob_ad[1], 32'h81);
        chk("mws_in",   ob_in[1], 32'h1234_5678);
        chk("mws_lat",  lat,      32'd2);
        load("lw_204", 2'b10, 1'b0, 32'h204, 32'h1234_5678);
`endif

        wc0 = wr_count;
        issue(1'b1, 2'b00, 1'b0, 32'h100, 32'h0000_0077);
        observe(2);
        rst = 1'b0;
        #1;
        chk("arst_ready",  {31'b0, bus.req_ready},  32'd1);
        chk("arst_rvalid", {31'b0, bus.resp_valid}, 32'd0);
        chk("arst_rdata",  bus.resp_rdata,          32'd0);
        chk("arst_err",    {31'b0, bus.resp_err},   32'd0);
        chk("arst_enable", {31'b0, DM_enable},      32'd0);
        chk("arst_write",  DM_write,                32'd0);
        chk("arst_in",     DM_in,                   32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        observe(3);
        chk("arst_no_strobe", en_cnt, 32'd0);
        chk("arst_no_resp",   lat,    32'd0);
        chk("arst_wr_count",  wr_count - wc0, 32'd0);
        chk("arst_mem",       mem[16'h40], 32'hCAFE_5AEF);
        load("lw_after_rst", 2'b10, 1'b0, 32'h100, 32'hCAFE_5AEF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dm_lsu.md
# dm_lsu

Load/store unit for the pipeline MEM stage; it is the initiator that drives the data memory port. It accepts byte, halfword and word requests at byte addresses, converts them to word accesses on `DM_*`, and returns aligned, sign- or zero-extended load data. Sub-word stores are done as read-modify-write, because the memory port writes whole words only.

## Interface
- Parameters: none. Address and data are fixed at 32 bits. Memory depth is the data memory's 65536 words.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit idle and able to accept a request.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word; 11 is treated as word.
- `req_unsigned` in 1: zero-extend a load when 1; sign-extend when 0.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-justified.
- `resp_valid` out 1: one-cycle completion pulse. There is no backpressure; the consumer must take it.
- `resp_rdata` out 32: load result; 0 for stores and errors.
- `resp_err` out 1: misaligned access; valid only when `resp_valid` is high.
- `DM_enable` out 1: memory access strobe.
- `DM_write` out 32: all-ones for a write, zero for a read.
- `DM_address` out 32: word index, equal to `addr[31:2]` zero-extended.
- `DM_in` out 32: write data.
- `DM_out` in 32: read data, valid in the cycle after a read strobe and zero otherwise.

## Operation
- A request is accepted on `req_valid && req_ready`. The unit registers addr, size, we, unsigned and wdata, and `req_ready` drops.
- FSM states: IDLE, RD, LD_DONE, MERGE, WR, ST_DONE, ERR.
- IDLE transitions on accept:
  - misaligned request goes to ERR;
  - load goes to RD;
  - word store goes to WR;
  - sub-word store goes to RD.
- RD: `DM_enable`=1, `DM_write`=0. The next state is LD_DONE for a load and MERGE for a store.
- LD_DONE: `resp_valid`=1. `resp_rdata` is the selected lane of `DM_out`, extended. Next state is IDLE.
- MERGE: `DM_out` is captured into the merge register. The store bytes replace the target lane. Next state is WR.
- WR: `DM_enable`=1, `DM_write`=all-ones. `DM_in` is wdata for a word store and the merge register for a sub-word store. Next state is ST_DONE.
- ST_DONE: `resp_valid`=1, `resp_rdata`=0. Next state is IDLE.
- ERR: `resp_valid`=1, `resp_err`=1. No memory strobe is issued. Next state is IDLE.
- Byte lanes are little-endian: lane k is `[8k+7:8k]` and corresponds to `addr[1:0]`=k. A halfword uses lanes {1,0} when `addr[1]`=0 and lanes {3,2} when `addr[1]`=1.
- Misaligned means: a half with `addr[0]`=1, or a word with `addr[1:0]`≠0.
- In every state other than RD and WR, `DM_enable`=0, `DM_write`=0 and `DM_in`=0.

## Timing
- The accept cycle is cycle A.
- Latency, measured as the cycle in which `resp_valid` is high:
  - load: A+2;
  - word store: A+2;
  - sub-word store: A+4;
  - error: A+1.
- `req_ready` is high only in IDLE. The next request can be accepted in the cycle after `resp_valid`.
- Reset values: state IDLE, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, all `DM_*` outputs 0. The merge register and request registers reset to 0.
- Reset asserted mid-operation aborts at once: no write strobe follows and no response is produced. Any write already strobed stands.
- In IDLE, `req_valid` without acceptance has no effect. Request inputs are ignored outside IDLE.

## Configuration
- `DM_LSU_MISALIGN_CHECK_EN`
- Defined: misaligned requests go to ERR as described in Operation.
- Undefined: the ERR state is omitted and `resp_err` is tied to 0. The address is aligned down (half: bit 0 cleared; word: bits 1:0 cleared) and the request proceeds normally.

## Structure
- `lsu_pkg` holds:
  - `lsu_size_e` (BYTE, HALF, WORD);
  - the `lsu_state_e` FSM enum;
  - the `DM_WR_ALL`=32'hFFFF_FFFF constant.
- Sub-module `dm_lsu_align` is purely combinational and performs:
  - load lane select and extension (size, offset, unsigned);
  - store lane merge (old word, wdata, size, offset).
- `dm_lsu` holds the FSM, the request registers and the merge register.

## Test plan
- Word store: 0xDEADBEEF at 0x100 → `DM_address`=0x40, `DM_write`=all-ones, `DM_in`=0xDEADBEEF at A+1; `resp_valid` at A+2.
- Signed byte load at 0x103 (after the word store) → `resp_rdata`=0xFFFFFFDE at A+2.
- Unsigned half load at 0x102 → 0x0000DEAD.
- Byte store 0x5A at 0x101 → read at A+1, write 0xDEAD5AEF at A+3, `resp_valid` at A+4.
- Half load at 0x101:
  - with the macro: `resp_err`=1 at A+1 and no `DM_enable` pulse;
  - without the macro: the address is treated as 0x100, giving 0xFFFFBEEF.
- Assert `rst` low during MERGE of a byte store → no WR strobe. Outputs match the reset values immediately. The memory word is unchanged, and `req_ready`=1 after release.
